fixed_mult_pipe: RTL and testbench

//  Pipelined signed fixed-point multiplier, two's-complement QN.Q format, replacing the

---
 rtl/fixed_mult_pkg.sv | 23 ++
 rtl/fixed_mult_if.sv | 24 ++
 rtl/fixed_round_sat.sv | 45 ++++
 rtl/fixed_mult_pipe.sv | 94 +++++++++
 tb/tb_fixed_mult_pipe.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fixed_mult_pkg.sv
// Shared constants for the fixed-point DSP datapath: rounding-mode encodings and
// saturation limits used by the multiplier and the accumulator blocks.
package fixed_mult_pkg;

  localparam logic RND_TRUNC  = 1'b0;
  localparam logic RND_HALFUP = 1'b1;

  // Wide enough to hold the limits for any operand width this datapath uses.
  localparam int SAT_W = 128;

  function automatic logic signed [SAT_W-1:0] sat_max(input int n);
    logic signed [SAT_W-1:0] one;
    one = {{(SAT_W-1){1'b0}}, 1'b1};
    return (one <<< (n - 1)) - one;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_min(input int n);
    logic signed [SAT_W-1:0] one;
    one = {{(SAT_W-1){1'b0}}, 1'b1};
    return -(one <<< (n - 1));
  endfunction

endpackage

// File: rtl/fixed_mult_if.sv
// Operand/result handshake bundle of the pipelined fixed-point multiplier.
interface fixed_mult_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_rnd;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_res;
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_rnd, out_ready,
    input  in_ready, out_valid, out_res, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_rnd, out_ready,
    output in_ready, out_valid, out_res, out_ovf
  );
endinterface

// File: rtl/fixed_round_sat.sv
// Scales a full-width signed product back to QN.Q with truncate or round-half-up,
// then saturates to the N-bit range and flags the clip.
module fixed_round_sat
  import fixed_mult_pkg::*;
#(
  parameter int N = 32,
  parameter int Q = 15
) (
  input  logic [2*N-1:0] p,
  input  logic           rnd,
  output logic [N-1:0]   res,
  output logic           ovf
);

  // One guard bit above the product so the rounding add can never wrap.
  localparam int W = 2 * N + 1;

  localparam logic signed [SAT_W-1:0] MAX_FULL = sat_max(N);
  localparam logic signed [SAT_W-1:0] MIN_FULL = sat_min(N);
  localparam logic signed [W-1:0]     MAX_W    = MAX_FULL[W-1:0];
  localparam logic signed [W-1:0]     MIN_W    = MIN_FULL[W-1:0];
  localparam logic signed [W-1:0]     HALF     = {{(W-1){1'b0}}, 1'b1} << (Q - 1);

  logic signed [W-1:0] p_ext;
  logic signed [W-1:0] biased;
  logic signed [W-1:0] r;

  // NOTE: every output gets a default at the top of the block so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    p_ext  = $signed({p[2*N-1], p});
    biased = (rnd == RND_HALFUP) ? p_ext + HALF : p_ext;
    r      = biased >>> Q;
    res    = r[N-1:0];
    ovf    = 1'b0;
    if (r > MAX_W) begin
      res = MAX_W[N-1:0];
      ovf = 1'b1;
    end else if (r < MIN_W) begin
      res = MIN_W[N-1:0];
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/fixed_mult_pipe.sv
// Three-stage pipelined signed QN.Q multiplier with valid/ready flow control:
// S1 operands, S2 full product, S3 rounded and saturated result.
module fixed_mult_pipe
  import fixed_mult_pkg::*;
#(
  parameter int N = 32,
  parameter int Q = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  fixed_mult_if.slave   bus
);

  logic                  v1, v2, v3;
  logic                  ready1, ready2, ready3;
  logic signed [N-1:0]   a1, b1;
  logic                  rnd1, rnd2;
  logic signed [2*N-1:0] p2;
  logic signed [2*N-1:0] prod;
  logic [N-1:0]          res3, res_c;
  logic                  ovf3, ovf_c;

  // A stage may load when it is empty or its content moves on this same edge,
  // which lets a full pipe push and pop together without bubbles.
  assign ready3 = !v3 || bus.out_ready;
  assign ready2 = !v2 || ready3;
  assign ready1 = !v1 || ready2;

  assign bus.in_ready  = ready1;
  assign bus.out_valid = v3;
  assign bus.out_res   = res3;
  assign bus.out_ovf   = ovf3;

  assign prod = $signed({{N{a1[N-1]}}, a1}) * $signed({{N{b1[N-1]}}, b1});

  // NOTE: payload registers are reset along with the valid bits so the output bus
  // reads zero during and right after reset instead of stale or unknown data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      a1   <= '0;
      b1   <= '0;
      rnd1 <= RND_TRUNC;
    end else if (ready1) begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge values
      // of its neighbours, independent of block ordering.
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        a1   <= bus.in_a;
        b1   <= bus.in_b;
        rnd1 <= bus.in_rnd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      p2   <= '0;
      rnd2 <= RND_TRUNC;
    end else if (ready2) begin
      v2 <= v1;
      if (v1) begin
        p2   <= prod;
        rnd2 <= rnd1;
      end
    end
  end

  fixed_round_sat #(
    .N (N),
    .Q (Q)
  ) u_round_sat (
    .p   (p2),
    .rnd (rnd2),
    .res (res_c),
    .ovf (ovf_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3   <= 1'b0;
      res3 <= '0;
      ovf3 <= 1'b0;
    end else if (ready3) begin
      v3 <= v2;
      if (v2) begin
        res3 <= res_c;
        ovf3 <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_fixed_mult_pipe.sv
// Self-checking bench for fixed_mult_pipe: directed corner cases, backpressure,
// mid-stream reset and a randomized stream scored against an arithmetic model.
module tb_fixed_mult_pipe;

  localparam int N = 32;
  localparam int Q = 15;

  typedef struct packed {
    logic [N-1:0] res;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_acc    = 0;
  int   n_pop    = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fixed_mult_if #(.N(N)) bus ();

  fixed_mult_pipe #(.N(N), .Q(Q)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer product, scaled with floor division, clipped to range.
  function automatic exp_t ref_mult(input logic [N-1:0] a, input logic [N-1:0] b,
                                    input logic rnd);
    longint p, r;
    exp_t   e;
    p = longint'($signed(a)) * longint'($signed(b));
    if (rnd) p = p + (longint'(1) <<< (Q - 1));
    r = p >>> Q;
    if (r > 64'sd2147483647) begin
      e.res = 32'h7FFF_FFFF;
      e.ovf = 1'b1;
    end else if (r < -64'sd2147483648) begin
      e.res = 32'h8000_0000;
      e.ovf = 1'b1;
    end else begin
      e.res = r[N-1:0];
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [N-1:0] rand_op();
    logic [15:0] lo;
    lo = 16'($urandom_range(0, 65535));
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return {{16{lo[15]}}, lo};
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard and hold-stability monitor, sampled mid-cycle.
  initial begin
    logic         held_vld;
    logic [N-1:0] held_res;
    logic         held_ovf;
    exp_t         e;
    held_vld = 1'b0;
    held_res = '0;
    held_ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_vld = 1'b0;
      end else begin
        if (held_vld && bus.out_valid) begin
          check("hold_res", bus.out_res, held_res);
          check("hold_ovf", bus.out_ovf, held_ovf);
        end
        held_vld = bus.out_valid && !bus.out_ready;
        held_res = bus.out_res;
        held_ovf = bus.out_ovf;
        if (bus.out_valid && bus.out_ready) begin
          n_pop++;
          check("pop_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("res", bus.out_res, e.res);
            check("ovf", bus.out_ovf, e.ovf);
          end
        end
      end
    end
  end

  task automatic drive_cycle(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic rnd, input logic ordy, output bit acc);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_rnd    = rnd;
    bus.out_ready = ordy;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    if (acc) begin
      exp_q.push_back(ref_mult(a, b, rnd));
      n_acc++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) break;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic directed(input logic [N-1:0] a, input logic [N-1:0] b, input logic rnd,
                          input logic [N-1:0] er, input logic eo);
    int lat;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_rnd    = rnd;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("dir_accept", bus.in_ready, 1);
    if (bus.in_ready) exp_q.push_back(exp_t'{res: er, ovf: eo});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    check("latency", lat, 3);
    drain();
  endtask

  initial begin
    bit acc;
    int acc0, pop0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_rnd    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_res", bus.out_res, 0);
    check("rst_out_ovf", bus.out_ovf, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // Directed arithmetic corners
    directed(32'h0000_C000, 32'h0001_0000, 1'b0, 32'h0001_8000, 1'b0);
    directed(32'hFFFF_8000, 32'h0000_4000, 1'b0, 32'hFFFF_C000, 1'b0);
    directed(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0);
    directed(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0);
    directed(32'h0000_0001, 32'h0000_4000, 1'b0, 32'h0000_0000, 1'b0);
    directed(32'h0000_0001, 32'h0000_4000, 1'b1, 32'h0000_0001, 1'b0);
    directed(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1);
    directed(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1);
    directed(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h8000_0000, 1'b1);
    directed(32'h0000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0);
    directed(32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);

    // Full-rate streaming
    acc0 = n_acc;
    pop0 = n_pop;
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, rand_op(), rand_op(), 1'($urandom), 1'b1, acc);
    check("tput_accepts", n_acc - acc0, 10);
    drain();
    check("tput_pops", n_pop - pop0, 10);

    // Backpressure: the pipe absorbs three pairs, then stalls the source
    acc0 = n_acc;
    pop0 = n_pop;
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, rand_op(), rand_op(), 1'($urandom), 1'b0, acc);
    check("bp_accepts", n_acc - acc0, 3);
    check("bp_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 50 && (n_acc - acc0) < 8; i++)
      drive_cycle(1'b1, rand_op(), rand_op(), 1'($urandom), 1'b1, acc);
    check("bp_total_accepts", n_acc - acc0, 8);
    drain();
    check("bp_pops", n_pop - pop0, 8);

    // Reset with three results in flight
    acc0 = n_acc;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, rand_op(), rand_op(), 1'($urandom), 1'b0, acc);
    check("fill_accepts", n_acc - acc0, 3);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("pre_rst_valid", bus.out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_res", bus.out_res, 0);
    check("midrst_out_ovf", bus.out_ovf, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    pop0 = n_pop;
    drain();
    check("no_stale_pops", n_pop - pop0, 0);
    directed(32'h0000_C000, 32'h0001_0000, 1'b0, 32'h0001_8000, 1'b0);

    // Randomized traffic with random source gaps and sink stalls
    acc0 = n_acc;
    pop0 = n_pop;
    for (int i = 0; i < 400; i++)
      drive_cycle($urandom_range(0, 3) != 0, rand_op(), rand_op(), 1'($urandom),
                  $urandom_range(0, 9) < 7, acc);
    drain();
    check("rand_pops", n_pop - pop0, n_acc - acc0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
